prbs_gen_chk: RTL and testbench

//  Parametrised LFSR PRBS generator plus self-synchronising PRBS checker for bit-error-rate measurement.

---
 rtl/prbs_gen_chk.sv | 185 ++++++++++++++++++
 tb/tb_prbs_gen_chk.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: LFSR PRBS generator with seed load and error injection, plus a
// self-synchronising PRBS checker that locks onto a received stream and then
// free-runs, counting checked bits and bit errors for BER measurement.
// LFSR state vectors are indexed [1:N]; bit 1 receives the newest feedback bit.
module prbs_gen_chk #(
  parameter int         N           = 7,
  parameter logic [1:N] TAPS        = 7'b0000011,
  parameter logic [1:N] INIT        = N'(1),
  parameter int         LOCK_THRESH = 16,
  parameter int         LOSS_THRESH = 8,
  parameter int         CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gen_en,
  input  logic             gen_load,
  input  logic [1:N]       gen_seed,
  input  logic             gen_inject,
  output logic             gen_bit,
  output logic             gen_valid,
  output logic [1:N]       gen_state,
  input  logic             chk_valid,
  input  logic             chk_bit,
  input  logic             chk_clear,
  output logic             chk_locked,
  output logic             chk_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int FW = $clog2(N + 1);
  localparam int MW = $clog2(LOCK_THRESH + 1);
  localparam int LW = $clog2(LOSS_THRESH + 1);

  localparam logic [FW-1:0] FILL_FULL = FW'(N);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_THRESH - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_THRESH - 1);

  typedef enum logic {SEARCH, LOCKED} chk_state_e;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---------------- generator ----------------
  logic [1:N] gen_state_q, gen_state_d;
  logic       gen_bit_q, gen_bit_d;
  logic       gen_valid_q, gen_valid_d;
  logic       gen_fb;

  assign gen_fb = ^(gen_state_q & TAPS);

  // Generator next state: load beats step; injection flips only the emitted bit.
  always_comb begin
    gen_state_d = gen_state_q;
    gen_bit_d   = gen_bit_q;
    gen_valid_d = 1'b0;
    if (gen_load) begin
      gen_state_d = (gen_seed == '0) ? INIT : gen_seed;
    end else if (gen_en) begin
      gen_bit_d   = gen_fb ^ gen_inject;
      gen_state_d = {gen_fb, gen_state_q[1:N-1]};
      gen_valid_d = 1'b1;
    end
  end

  // Generator registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      gen_state_q <= INIT;
      gen_bit_q   <= 1'b0;
      gen_valid_q <= 1'b0;
    end else begin
      gen_state_q <= gen_state_d;
      gen_bit_q   <= gen_bit_d;
      gen_valid_q <= gen_valid_d;
    end
  end

  assign gen_bit   = gen_bit_q;
  assign gen_valid = gen_valid_q;
  assign gen_state = gen_state_q;

  // ---------------- checker ----------------
  chk_state_e       state_q, state_d;
  logic [1:N]       chk_reg_q, chk_reg_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic [LW-1:0]    miss_q, miss_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             exp_bit;
  logic             miss;

  assign exp_bit = ^(chk_reg_q & TAPS);
  assign miss    = chk_bit ^ exp_bit;

  // Checker FSM: SEARCH shifts in received bits until enough predictions hold,
  // LOCKED shifts in its own predictions so a single bad bit counts only once.
  always_comb begin
    state_d   = state_q;
    chk_reg_d = chk_reg_q;
    fill_d    = fill_q;
    match_d   = match_q;
    miss_d    = miss_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if (chk_valid) begin
      case (state_q)
        SEARCH: begin
          chk_reg_d = {chk_bit, chk_reg_q[1:N-1]};
          if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 1'b1;
          end else if (!miss && (chk_reg_q != '0)) begin
            if (match_q == LOCK_LAST) begin
              state_d = LOCKED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            // An all-zero register predicts zeros forever; never lock on it.
            match_d = '0;
          end
        end
        LOCKED: begin
          chk_reg_d = {exp_bit, chk_reg_q[1:N-1]};
          bit_cnt_d = sat_inc(bit_cnt_q);
          if (miss) begin
            err_d     = 1'b1;
            err_cnt_d = sat_inc(err_cnt_q);
            if (miss_q == LOSS_LAST) begin
              state_d = SEARCH;
              fill_d  = '0;
              match_d = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    if (chk_clear) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  // Checker registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SEARCH;
      chk_reg_q <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      chk_reg_q <= chk_reg_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign chk_locked = (state_q == LOCKED);
  assign chk_err    = err_q;
  assign err_cnt    = err_cnt_q;
  assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Bench for prbs_gen_chk: a default instance and a CNT_W=4 instance share the
// same stimulus; generator bits are scoreboarded against an independent
// x^7+x^6+1 model, checker behaviour is checked against spec-level events.
module tb_prbs_gen_chk;

  logic        clk = 1'b0;
  logic        reset, gen_en, gen_load, gen_inject, chk_clear;
  logic [1:7]  gen_seed;
  logic        loop, flip, tb_valid, tb_bit;
  wire         chk_valid, chk_bit;

  logic        gen_bit, gen_valid, chk_locked, chk_err;
  logic [1:7]  gen_state;
  logic [31:0] err_cnt, bit_cnt;

  logic        gen_bit4, gen_valid4, chk_locked4, chk_err4;
  logic [1:7]  gen_state4;
  logic [3:0]  err_cnt4, bit_cnt4;

  int n_checks = 0;
  int n_fail   = 0;
  int nv       = 0;
  int n_pulse  = 0;
  int nv_lock  = 0;
  int bits_before = 0;

  logic [6:0] m_state;
  bit         gq[$];

  always #5 clk = ~clk;

  assign chk_valid = loop ? gen_valid : tb_valid;
  assign chk_bit   = loop ? (gen_bit ^ flip) : tb_bit;

  prbs_gen_chk dut (
    .clk(clk), .reset(reset), .gen_en(gen_en), .gen_load(gen_load),
    .gen_seed(gen_seed), .gen_inject(gen_inject), .gen_bit(gen_bit),
    .gen_valid(gen_valid), .gen_state(gen_state), .chk_valid(chk_valid),
    .chk_bit(chk_bit), .chk_clear(chk_clear), .chk_locked(chk_locked),
    .chk_err(chk_err), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );

  prbs_gen_chk #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .gen_en(gen_en), .gen_load(gen_load),
    .gen_seed(gen_seed), .gen_inject(gen_inject), .gen_bit(gen_bit4),
    .gen_valid(gen_valid4), .gen_state(gen_state4), .chk_valid(chk_valid),
    .chk_bit(chk_bit), .chk_clear(chk_clear), .chk_locked(chk_locked4),
    .chk_err(chk_err4), .err_cnt(err_cnt4), .bit_cnt(bit_cnt4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: predict the generator, clock, then compare away from the edge.
  task automatic tick();
    bit fb, ev, vpre;
    ev   = !reset && !gen_load && gen_en;
    vpre = loop ? gen_valid : tb_valid;
    if (reset) begin
      m_state = 7'd1;
      gq.delete();
    end else if (gen_load) begin
      m_state = (gen_seed == 7'd0) ? 7'd1 : gen_seed;
    end else if (gen_en) begin
      fb = m_state[0] ^ m_state[1];
      gq.push_back(fb ^ gen_inject);
      m_state = {fb, m_state[6:1]};
    end
    @(posedge clk);
    #1;
    check_eq("gen_valid", gen_valid, ev);
    check_eq("gen_state", gen_state, m_state);
    if (gen_valid) begin
      if (gq.size() == 0) check_eq("gen_queue_empty", 1, 0);
      else                check_eq("gen_bit", gen_bit, gq.pop_front());
    end
    if (chk_err) n_pulse++;
    if (vpre) nv++;
  endtask

  task automatic run_bits(input int n);
    int base;
    base = nv;
    for (int i = 0; i < 2 * n + 20 && (nv - base) < n; i++) tick();
    if ((nv - base) != n) check_eq("run_bits_timeout", nv - base, n);
  endtask

  // Lock must appear right after the 23rd valid bit (7 fill + 16 matches).
  task automatic expect_lock(input string tag);
    int base;
    bit seen;
    base = nv;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if ((nv - base) == 22) check_eq({tag, "_before"}, chk_locked, 0);
      if ((nv - base) == 23) begin
        check_eq({tag, "_locked"}, chk_locked, 1);
        check_eq({tag, "_locked4"}, chk_locked4, 1);
        seen = 1;
      end
    end
    if (!seen) check_eq({tag, "_timeout"}, 0, 1);
    nv_lock = nv;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_state"}, gen_state, 7'd1);
    check_eq({tag, "_bit"}, gen_bit, 0);
    check_eq({tag, "_valid"}, gen_valid, 0);
    check_eq({tag, "_locked"}, chk_locked, 0);
    check_eq({tag, "_err"}, chk_err, 0);
    check_eq({tag, "_errcnt"}, err_cnt, 0);
    check_eq({tag, "_bitcnt"}, bit_cnt, 0);
    check_eq({tag, "_errcnt4"}, err_cnt4, 0);
    check_eq({tag, "_bitcnt4"}, bit_cnt4, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_ret, p0, nv_drop;
    bit zero_seen, lock_seen;
    reset = 1; gen_en = 0; gen_load = 0; gen_inject = 0; chk_clear = 0;
    gen_seed = '0; loop = 1; flip = 0; tb_valid = 0; tb_bit = 0;
    m_state = 7'd1;
    #2;
    tick(); tick();
    check_reset_vals("reset0");
    reset = 0;

    // Period of the maximal-length sequence
    gen_en = 1; first_ret = 0; zero_seen = 0;
    for (int k = 1; k <= 200 && first_ret == 0; k++) begin
      tick();
      if (gen_state == 7'd0) zero_seen = 1;
      if (gen_state == 7'd1) first_ret = k;
    end
    check_eq("period", first_ret, 127);
    check_eq("never_zero", zero_seen, 0);
    tick(); tick();

    // Seed load, zero seed replaced by INIT, load beats gen_en
    gen_load = 1; gen_seed = 7'd0;
    tick();
    check_eq("load_zero_state", gen_state, 7'd1);
    gen_seed = 7'h55;
    tick();
    check_eq("load55_state", gen_state, 7'h55);
    check_eq("load55_valid", gen_valid, 0);
    gen_load = 0;
    repeat (10) tick();

    // Mid-operation reset, then loopback lock and 1000 clean bits
    reset = 1; gen_en = 0;
    tick();
    check_reset_vals("reset1");
    reset = 0; gen_en = 1;
    expect_lock("lock3");
    check_eq("lock3_bitcnt", bit_cnt, 0);
    run_bits(1000);
    check_eq("clean_errcnt", err_cnt, 0);
    check_eq("clean_bitcnt", bit_cnt, 1000);
    check_eq("clean_bitcnt4_sat", bit_cnt4, 15);
    check_eq("clean_errcnt4", err_cnt4, 0);

    // Single injected error
    p0 = n_pulse;
    gen_inject = 1; tick(); gen_inject = 0;
    run_bits(20);
    check_eq("inject_pulses", n_pulse - p0, 1);
    check_eq("inject_errcnt", err_cnt, 1);
    check_eq("inject_errcnt4", err_cnt4, 1);
    check_eq("inject_locked", chk_locked, 1);
    check_eq("inject_bitcnt", bit_cnt, nv - nv_lock);

    // All-zero stream must not lock
    reset = 1; gen_en = 0; loop = 0; tb_valid = 1; tb_bit = 0;
    tick();
    reset = 0; lock_seen = 0;
    repeat (500) begin
      tick();
      if (chk_locked) lock_seen = 1;
    end
    check_eq("zero_stream_nolock", lock_seen, 0);
    check_eq("zero_stream_bits", bit_cnt, 0);

    // Lock, then 8 consecutive inverted bits drop lock, then relock
    reset = 1; tick();
    reset = 0; loop = 1; tb_valid = 0; gen_en = 1;
    expect_lock("lock5a");
    run_bits(10);
    p0 = n_pulse;
    for (int i = 1; i <= 8; i++) begin
      flip = 1;
      tick();
      if (i == 7) check_eq("loss_after7", chk_locked, 1);
      if (i == 8) check_eq("loss_after8", chk_locked, 0);
    end
    flip = 0;
    nv_drop = nv;
    check_eq("loss_errcnt", err_cnt, 8);
    check_eq("loss_pulses", n_pulse - p0, 8);
    check_eq("loss_bitcnt", bit_cnt, nv_drop - nv_lock);
    bits_before = nv_drop - nv_lock;
    expect_lock("lock5b");
    check_eq("relock_errcnt", err_cnt, 8);
    check_eq("relock_bitcnt", bit_cnt, bits_before);

    // Saturation with 20 spaced errors, then clear beats a counted bit
    p0 = n_pulse;
    for (int i = 0; i < 20; i++) begin
      gen_inject = 1; tick();
      gen_inject = 0; tick();
    end
    run_bits(5);
    check_eq("sat_pulses", n_pulse - p0, 20);
    check_eq("sat_errcnt", err_cnt, 28);
    check_eq("sat_errcnt4", err_cnt4, 15);
    check_eq("sat_bitcnt4", bit_cnt4, 15);
    check_eq("sat_locked", chk_locked, 1);
    check_eq("sat_bitcnt", bit_cnt, bits_before + (nv - nv_lock));
    gen_inject = 1; tick(); gen_inject = 0;
    chk_clear = 1; tick(); chk_clear = 0;
    check_eq("clear_err_pulse", chk_err, 1);
    check_eq("clear_errcnt", err_cnt, 0);
    check_eq("clear_bitcnt", bit_cnt, 0);
    check_eq("clear_errcnt4", err_cnt4, 0);
    check_eq("clear_bitcnt4", bit_cnt4, 0);
    check_eq("clear_locked", chk_locked, 1);
    tick();
    check_eq("after_clear_bitcnt", bit_cnt, 1);
    check_eq("after_clear_bitcnt4", bit_cnt4, 1);
    check_eq("after_clear_errcnt", err_cnt, 0);
    check_eq("after_clear_err", chk_err, 0);

    gen_en = 0;
    tick(); tick();
    check_eq("gen_queue_drained", gq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
